// File: rtl/handshake_const_arbiter_pkg.sv
// const_arb_pkg: shared widths and helpers for the constant-token arbiter.
package const_arb_pkg;
    localparam int STATS_CNT_W = 16;
    localparam logic [STATS_CNT_W-1:0] STATS_CNT_MAX = '1;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/handshake_const_arbiter_if.sv
// handshake_const_arbiter_if: per-requester control channels plus the shared output channel.
interface handshake_const_arbiter_if import const_arb_pkg::*; #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
) ();
    localparam int IDX_W = idx_w(N_REQ);
    logic [N_REQ-1:0]      ctrl_valid;
    logic [N_REQ-1:0]      ctrl_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic [IDX_W-1:0]      outs_index;
    logic                  outs_valid;
    logic                  outs_ready;
    modport master (output ctrl_valid, outs_ready, input ctrl_ready, outs, outs_index, outs_valid);
    modport slave (input ctrl_valid, outs_ready, output ctrl_ready, outs, outs_index, outs_valid);
endinterface

// File: rtl/handshake_const_arbiter_rr_grant_picker.sv
// rr_grant_picker: combinational round-robin pick, first request at or after ptr with wrap.
module rr_grant_picker import const_arb_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);
    logic [IDX_W:0] s, c;
    // Walk offsets from far to near so the nearest request overwrites earlier picks.
    always_comb begin
        idx = '0;
        s = '0;
        c = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (IDX_W+1)'(k);
            c = (s >= N_W) ? s - N_W : s;
            if (req[c[IDX_W-1:0]]) idx = c[IDX_W-1:0];
        end
    end
    assign any = |req;
    assign grant = any ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/handshake_const_arbiter.sv
// handshake_const_arbiter: round-robin share of a constant table onto one registered output channel.
// Defining CONST_ARB_STATS_EN adds per-requester saturating grant counters on grant_count.
module handshake_const_arbiter import const_arb_pkg::*; #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter logic [N_REQ*DATA_WIDTH-1:0] CONST_TABLE = '0
) (
    input  logic clk,
    input  logic rst,
    handshake_const_arbiter_if.slave bus
`ifdef CONST_ARB_STATS_EN
    ,
    output logic [N_REQ*STATS_CNT_W-1:0] grant_count
`endif
);
    localparam int IDX_W = idx_w(N_REQ);
    logic                  full, load_en, any, accept;
    logic [IDX_W-1:0]      ptr, g, out_idx;
    logic [N_REQ-1:0]      gnt;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] tbl [N_REQ];
    for (genvar i = 0; i < N_REQ; i++) begin : g_tbl
        assign tbl[i] = CONST_TABLE[i*DATA_WIDTH +: DATA_WIDTH];
    end
    rr_grant_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (bus.ctrl_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (g),
        .any   (any)
    );
    assign load_en        = !full || bus.outs_ready;
    assign accept         = load_en && any && !rst;
    assign bus.ctrl_ready = accept ? gnt : '0;
    assign bus.outs_valid = full;
    assign bus.outs       = out_data;
    assign bus.outs_index = out_idx;
    // An accept during a drain simply overwrites the slot, keeping full set.
    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            ptr      <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else if (accept) begin
            full     <= 1'b1;
            out_data <= tbl[g];
            out_idx  <= g;
            ptr      <= (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
        end else if (bus.outs_ready) begin
            full <= 1'b0;
        end
    end
`ifdef CONST_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stats
        logic [STATS_CNT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst) cnt <= '0;
            else if (bus.ctrl_ready[i] && cnt != STATS_CNT_MAX) cnt <= cnt + 1'b1;
        end
        assign grant_count[i*STATS_CNT_W +: STATS_CNT_W] = cnt;
    end
`endif
endmodule

// File: tb/tb_handshake_const_arbiter.sv
// tb_handshake_const_arbiter: directed and random stimulus against a cycle-level reference model.
module tb_handshake_const_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int m_full, m_out, m_idx, m_ptr;
    int m_cnt [N];
    logic [N-1:0] last_rdy;
    handshake_const_arbiter_if #(.N_REQ(N), .DATA_WIDTH(32)) bus ();
`ifdef CONST_ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif
    handshake_const_arbiter #(
        .N_REQ(N),
        .DATA_WIDTH(32),
        .CONST_TABLE({32'h40, 32'h30, 32'h20, 32'h10})
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CONST_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction
    task automatic model_reset();
        m_full = 0; m_out = 0; m_idx = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask
    // Drive one cycle from a negedge, check outputs against the model, then advance it.
    task automatic step(input logic [N-1:0] v, input logic r);
        int g;
        logic [N-1:0] er;
        bus.ctrl_valid = v;
        bus.outs_ready = r;
        #1;
        g = pick(v, m_ptr);
        er = ((m_full == 0 || r) && g >= 0) ? N'(1) << g : '0;
        check("ctrl_ready", 32'(bus.ctrl_ready), 32'(er));
        check("outs_valid", 32'(bus.outs_valid), 32'(m_full));
        check("outs", bus.outs, 32'(m_out));
        check("outs_index", 32'(bus.outs_index), 32'(m_idx));
        last_rdy = bus.ctrl_ready;
        @(posedge clk);
        if (er != 0) begin
            m_full = 1; m_out = 16 * (g + 1); m_idx = g; m_ptr = (g + 1) % N;
            m_cnt[g]++;
        end else if (r) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        logic [N-1:0] pend, v;
        bus.ctrl_valid = '0;
        bus.outs_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        step('0, 1'b0);
        for (int i = 0; i < 6; i++) step(4'hF, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b1);
        step(4'hF, 1'b1);
        for (int i = 0; i < 5; i++) step(4'hF, 1'b0);
        step(4'hF, 1'b1);
        step(4'b0010, 1'b1);
        for (int i = 0; i < 2; i++) step('0, 1'b1);
        step(4'b0100, 1'b0);
        step(4'hF, 1'b0);
        bus.ctrl_valid = 4'hF;
        do_reset();
        step('0, 1'b0);
        step(4'hF, 1'b1);
        step('0, 1'b1);
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            v = pend | N'($urandom_range(0, 15) & $urandom_range(0, 15));
            step(v, 1'($urandom_range(0, 3) != 0));
            pend = v & ~last_rdy;
        end
`ifdef CONST_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("grant_count", 32'(grant_count[i*16 +: 16]), 32'(m_cnt[i]));
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/handshake_const_arbiter.md
Name: handshake_const_arbiter

Overview:
- Shares one constant-token source among N_REQ requesters in the elastic dataflow fabric.
- Each requester sends a control token on its own valid/ready channel. The block round-robin arbitrates, and emits that requester's programmed constant plus its index on a single registered output channel.
- It sits between loop/branch control tokens and a shared downstream consumer, such as a memory port or an operator.

Parameters:
- N_REQ, 4, number of requesting control channels (1..16).
- DATA_WIDTH, 32, width of each constant and of outs.
- CONST_TABLE, all zeros, packed N_REQ*DATA_WIDTH constant table; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ctrl_valid  input  N_REQ  per-requester control token valid.
- ctrl_ready  output  N_REQ  per-requester ready; one-hot or zero.
- outs  output  DATA_WIDTH  constant of the granted requester.
- outs_index  output  IDX_W  granted requester index; IDX_W = max(1, clog2(N_REQ)).
- outs_valid  output  1  output token valid.
- outs_ready  input  1  downstream ready.

Behaviour:
- State:
  - full: output slot occupied.
  - ptr: round-robin pointer, IDX_W bits.
  - outs and outs_index registers.
- Reset (rst=1 at clk edge):
  - full=0, ptr=0, outs=0, outs_index=0.
  - outs_valid=0 and ctrl_ready=0 during the following cycle.
  - A held, undelivered token is dropped. No partial state survives.
- Slot rules:
  - load_en = !full || outs_ready.
  - outs_valid = full.
- Arbitration (combinational):
  - Search ctrl_valid starting at ptr, ascending with wrap N_REQ-1 -> 0. The first asserted index is g.
  - any_req = |ctrl_valid.
- Grant: ctrl_ready[g] = load_en && any_req. All other ctrl_ready bits are 0. At most one token is accepted per cycle.
- On an accepted token:
  - outs <= CONST_TABLE[g] and outs_index <= g.
  - full <= 1.
  - ptr <= (g == N_REQ-1) ? 0 : g+1.
- Drain: full && outs_ready && !any_req -> full <= 0. outs and outs_index hold their last values.
- Simultaneous drain and accept: the new token replaces the old one in the same edge, full stays 1. This gives sustained throughput of 1 token/cycle.
- Backpressure: while full && !outs_ready, outs, outs_index and outs_valid stay stable. All ctrl_ready are 0 and ptr is frozen.
- Latency: one cycle from ctrl handshake to outs_valid.
- Combinational paths:
  - outs_ready -> ctrl_ready.
  - ctrl_valid -> ctrl_ready.
  - There is no path from any input to outs, outs_valid or outs_index.
- Fairness: a requester that holds valid is granted within N_REQ accepted tokens.
- N_REQ=1: ptr stays 0, and g=0 whenever ctrl_valid[0]=1.
- Requesters must hold ctrl_valid until they see ready. A valid that drops without a handshake is simply not considered.

Optional Feature:
- Macro: CONST_ARB_STATS_EN.
- Defined:
  - Adds output port grant_count, N_REQ*16 bits.
  - Holds one saturating 16-bit counter per requester, at bits [i*16 +: 16].
  - The counter increments on each accepted token from requester i and saturates at 16'hFFFF.
  - All counters clear on rst.
- Undefined: the port and the counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package const_arb_pkg holds:
  - clog2-based IDX_W function.
  - STATS_CNT_W = 16.
  - STATS_CNT_MAX.
- One sub-module: rr_grant_picker.
  - Purely combinational.
  - Inputs: req[N_REQ], ptr.
  - Outputs: one-hot grant, grant index, any.
  - Reusable by other shared-resource controllers.

Test Plan:
- Reset mid-stream: token held, outs_ready=0, assert rst for one cycle -> next cycle outs_valid=0, outs=0, ctrl_ready=0; first grant afterwards goes to requester 0.
- N_REQ=4, CONST_TABLE={4,3,2,1} × 0x10 (entry i = 0x10*(i+1)), all ctrl_valid=1, outs_ready=1 -> outs sequence 0x10,0x20,0x30,0x40,0x10…, outs_index 0,1,2,3,0, one token per cycle.
- Single requester 2 valid, outs_ready=1 -> ctrl_ready=4'b0100 each cycle, outs=0x30, outs_index=2 from the cycle after the first handshake.
- Backpressure: load the slot, outs_ready=0 for 5 cycles with all requests valid -> outs, outs_index stable; ctrl_ready=0; ptr unchanged; release -> next grant is (last index + 1) mod 4.
- Drain without request: one token accepted, then ctrl_valid=0 with outs_ready=1 -> outs_valid falls after one cycle; outs holds its value.
- CONST_ARB_STATS_EN defined, 70000 grants to requester 1 -> grant_count[31:16]=16'hFFFF; other counters match their own grant counts exactly.
